e_mdu: RTL and testbench
========================

// Module: e_mdu
// PURPOSE
//  E-stage multiply/divide unit of the 5-stage MIPS pipeline. Owns HI/LO; runs mult/div
//  ops over a fixed multi-cycle latency; serves mfhi/mflo/mthi/mtlo.
//  Drives hilo_busy to the hazard unit, which stalls any D-stage HI/LO instruction while it is high.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for MULT/MULTU (and MADD* when enabled); legal range >=1
//  DIV_CYCLES   10  busy cycles for DIV/DIVU; legal range >=1
// PORTS
//  clk        in   1   pipeline clock, rising edge
//  reset_n    in   1   asynchronous, active-low reset
//  start      in   1   E-stage instruction is an MDU op this cycle (one-cycle qualifier)
//  mdu_op     in   4   0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 MFHI,8 MFLO,
//                      9 MADD,10 MADDU,11 MSUB,12 MSUBU; all other codes = NONE
//  rs_val     in   32  forwarded rs operand
//  rt_val     in   32  forwarded rt operand
//  busy       out  1   long op in progress
//  hilo_busy  out  1   busy | (start & mdu_op is a long op); feeds the hazard unit
//  mdu_out    out  32  combinational: HI if mdu_op==MFHI, LO if mdu_op==MFLO, else 0
//  hi, lo     out  32  architectural HI/LO registers
// BEHAVIOUR
//  - Reset (reset_n=0, async): hi=lo=0, busy=0, counter=0, latched result=0.
//    Reset mid-operation aborts the op; HI/LO stay 0.
//  - FSM: IDLE, RUN.
//    - IDLE, start & long op: latch the 64-bit result computed from rs_val/rt_val.
//      Load cnt=N-1 (N=MULT_CYCLES or DIV_CYCLES). Go to RUN; busy=1 from the next cycle.
//    - RUN: cnt decrements each cycle. At the edge where cnt==0: commit the result to {hi,lo},
//      clear busy, return to IDLE. Busy stays high for exactly N cycles.
//      New HI/LO are visible the first cycle busy=0.
//  - start while busy=1: ignored entirely, including MTHI/MTLO. The hazard unit guarantees
//    this does not occur.
//  - MTHI/MTLO with start in IDLE: write rs_val to hi/lo at that edge; no busy.
//  - MFHI/MFLO: no state change; mdu_out is read in the same cycle.
//  - hilo_busy is combinational: high during the start cycle of a long op and every busy cycle.
//  - Arithmetic:
//    - MULT: signed 32x32->64; MULTU: unsigned. Result {hi,lo}.
//    - DIV/DIVU: lo=quotient (truncate toward zero), hi=remainder (sign of dividend).
//    - Divide by zero: full DIV_CYCLES busy, then hi/lo unchanged.
//    - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
//  - Ops 9-12 with MDU_MADD_EN undefined: treated as NONE (no busy, no HI/LO change).
// CONFIGURATION
//  MDU_MADD_EN defined:
//   - MADD/MADDU: {hi,lo} += signed/unsigned rs*rt (64-bit, wraps mod 2^64).
//   - MSUB/MSUBU: {hi,lo} -= product.
//   - The accumulate uses the {hi,lo} value at commit time. MULT_CYCLES latency.
//   - These ops count as long ops for hilo_busy.
//  MDU_MADD_EN undefined: no accumulate datapath; codes 9-12 decode as NONE.
// TESTING
//  1 Reset: reset_n=0 mid-DIV -> busy=0 and hi=lo=0 immediately; no commit after release.
//  2 MULT rs=0xFFFFFFFD, rt=5:
//     - busy high 5 cycles, hilo_busy high 6 cycles.
//     - Then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
//     - MULTU with the same operands -> hi=0x00000004, lo=0xFFFFFFF1.
//  3 DIV rs=0xFFFFFFF9 (-7), rt=2:
//     - After 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     - DIVU 7/0 -> busy 10 cycles, hi/lo unchanged.
//  4 MTHI 0x1234 during busy -> ignored, and the pending result commits.
//     MTHI 0x1234 in IDLE -> hi=0x1234 next cycle; MFHI gives mdu_out=0x1234 combinationally.
//  5 Back-to-back: DIV start on the cycle after busy falls -> accepted.
//     The prior result is visible on the same cycle the new op starts.
//  6 (MDU_MADD_EN) hi=0, lo=0xFFFFFFFF, then MADDU 1*1:
//     - After 5 cycles hi=1, lo=0.
//     - MSUB 1*1 -> hi=0, lo=0xFFFFFFFF.

Source files
------------

// File: rtl/e_mdu.sv
// ---------------------------------------------------------------------------------------------
// e_mdu -- E-stage multiply/divide unit for the 5-stage MIPS pipeline.
//
// Owns the architectural HI/LO registers. MULT/MULTU/DIV/DIVU latch their 64-bit result when
// they start and commit it to {hi,lo} after a fixed busy period. MTHI/MTLO write in one cycle.
// MFHI/MFLO are served combinationally on mdu_out.
//
// Optional feature: define MDU_MADD_EN to add MADD/MADDU/MSUB/MSUBU. These accumulate into
// {hi,lo} and use MULT_CYCLES latency. With the macro undefined, op codes 9-12 decode as NONE.
//
// Parameters:
//   MULT_CYCLES  busy cycles for multiplies (>=1)
//   DIV_CYCLES   busy cycles for divides (>=1)
//
// Ports:
//   clk        in   1   rising-edge clock
//   reset_n    in   1   asynchronous active-low reset
//   start      in   1   E-stage instruction is an MDU op this cycle
//   mdu_op     in   4   operation code
//   rs_val     in   32  forwarded rs operand
//   rt_val     in   32  forwarded rt operand
//   busy       out  1   long op in progress
//   hilo_busy  out  1   busy, or a long op is starting this cycle (to hazard unit)
//   mdu_out    out  32  HI for MFHI, LO for MFLO, else 0
//   hi, lo     out  32  architectural HI/LO
// ---------------------------------------------------------------------------------------------
module e_mdu #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [3:0]  mdu_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        busy,
   output logic        hilo_busy,
   output logic [31:0] mdu_out,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [3:0] OpMult  = 4'd1;
   localparam logic [3:0] OpMultu = 4'd2;
   localparam logic [3:0] OpDiv   = 4'd3;
   localparam logic [3:0] OpDivu  = 4'd4;
   localparam logic [3:0] OpMthi  = 4'd5;
   localparam logic [3:0] OpMtlo  = 4'd6;
   localparam logic [3:0] OpMfhi  = 4'd7;
   localparam logic [3:0] OpMflo  = 4'd8;
`ifdef MDU_MADD_EN
   localparam logic [3:0] OpMadd  = 4'd9;
   localparam logic [3:0] OpMaddu = 4'd10;
   localparam logic [3:0] OpMsub  = 4'd11;
   localparam logic [3:0] OpMsubu = 4'd12;
`endif

   localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

   typedef enum logic {StIdle, StRun} state_e;

   // What to do with res_q at commit time.
   typedef enum logic [1:0] {KindSet, KindAdd, KindSub, KindNone} kind_e;

   state_e            state_q, state_d;
   kind_e             kind_q, kind_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [63:0]       res_q, res_d;
   logic [31:0]       hi_q, hi_d;
   logic [31:0]       lo_q, lo_d;
   logic              busy_q, busy_d;

   // ---------------------------------------------------------------------------------------
   // Decode
   // ---------------------------------------------------------------------------------------
   logic is_mul, is_div, is_acc, is_long;

   always_comb begin
      is_mul = (mdu_op == OpMult) || (mdu_op == OpMultu);
      is_div = (mdu_op == OpDiv) || (mdu_op == OpDivu);
`ifdef MDU_MADD_EN
      is_acc = (mdu_op == OpMadd) || (mdu_op == OpMaddu) ||
               (mdu_op == OpMsub) || (mdu_op == OpMsubu);
`else
      is_acc = 1'b0;
`endif
      is_long = is_mul || is_div || is_acc;
   end

   // ---------------------------------------------------------------------------------------
   // Arithmetic
   // ---------------------------------------------------------------------------------------
   logic [63:0] prod_s, prod_u;
   logic        div_signed, rs_neg, rt_neg;
   logic [31:0] rs_mag, rt_mag, rt_safe, q_mag, r_mag, quot, rem;

   always_comb begin
      // Sign-extended 64x64 product truncated to 64 bits equals the signed 32x32 product.
      prod_u = {32'd0, rs_val} * {32'd0, rt_val};
      prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};

      // Divide on magnitudes, then restore signs: quotient truncates toward zero and the
      // remainder takes the dividend's sign. 0x80000000 / -1 falls out as 0x80000000 r 0.
      div_signed = (mdu_op == OpDiv);
      rs_neg     = div_signed & rs_val[31];
      rt_neg     = div_signed & rt_val[31];
      rs_mag     = rs_neg ? (32'd0 - rs_val) : rs_val;
      rt_mag     = rt_neg ? (32'd0 - rt_val) : rt_val;
      // Divide-by-zero never commits; keep the divider inputs defined anyway.
      rt_safe    = (rt_mag == 32'd0) ? 32'd1 : rt_mag;
      q_mag      = rs_mag / rt_safe;
      r_mag      = rs_mag % rt_safe;
      quot       = (rs_neg ^ rt_neg) ? (32'd0 - q_mag) : q_mag;
      rem        = rs_neg ? (32'd0 - r_mag) : r_mag;
   end

   // ---------------------------------------------------------------------------------------
   // Next state
   // ---------------------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      kind_d  = kind_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      busy_d  = busy_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (is_mul) begin
                  res_d   = (mdu_op == OpMult) ? prod_s : prod_u;
                  kind_d  = KindSet;
                  cnt_d   = CntW'(MULT_CYCLES - 1);
                  state_d = StRun;
                  busy_d  = 1'b1;
               end else if (is_div) begin
                  res_d   = {rem, quot};
                  kind_d  = (rt_val == 32'd0) ? KindNone : KindSet;
                  cnt_d   = CntW'(DIV_CYCLES - 1);
                  state_d = StRun;
                  busy_d  = 1'b1;
`ifdef MDU_MADD_EN
               end else if (is_acc) begin
                  res_d   = ((mdu_op == OpMadd) || (mdu_op == OpMsub)) ? prod_s : prod_u;
                  kind_d  = ((mdu_op == OpMadd) || (mdu_op == OpMaddu)) ? KindAdd : KindSub;
                  cnt_d   = CntW'(MULT_CYCLES - 1);
                  state_d = StRun;
                  busy_d  = 1'b1;
`endif
               end else if (mdu_op == OpMthi) begin
                  hi_d = rs_val;
               end else if (mdu_op == OpMtlo) begin
                  lo_d = rs_val;
               end
            end
         end

         StRun: begin
            // Any start while running is dropped; the hazard unit keeps that from happening.
            if (cnt_q == '0) begin
               state_d = StIdle;
               busy_d  = 1'b0;
               case (kind_q)
                  KindSet: {hi_d, lo_d} = res_q;
`ifdef MDU_MADD_EN
                  // Accumulate against HI/LO as they stand at commit.
                  KindAdd: {hi_d, lo_d} = {hi_q, lo_q} + res_q;
                  KindSub: {hi_d, lo_d} = {hi_q, lo_q} - res_q;
`endif
                  default: ;
               endcase
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
      endcase
   end

   // ---------------------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         kind_q  <= KindNone;
         cnt_q   <= '0;
         res_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
      end
   end

   // ---------------------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------------------
   always_comb begin
      busy      = busy_q;
      hilo_busy = busy_q | (start & is_long);
      hi        = hi_q;
      lo        = lo_q;
      mdu_out   = 32'd0;
      if (mdu_op == OpMfhi) begin
         mdu_out = hi_q;
      end else if (mdu_op == OpMflo) begin
         mdu_out = lo_q;
      end
   end

endmodule

// File: tb/tb_e_mdu.sv
// ---------------------------------------------------------------------------------------------
// tb_e_mdu -- self-checking bench for e_mdu with default latencies (MULT 5, DIV 10).
// Expected HI/LO values are pushed to a queue as each long op is issued and popped when busy
// falls. Inputs change on the falling edge; outputs are sampled on the falling edge or 1 time
// unit after an input change.
// ---------------------------------------------------------------------------------------------
module tb_e_mdu;

   localparam logic [3:0] OpNone  = 4'd0;
   localparam logic [3:0] OpMult  = 4'd1;
   localparam logic [3:0] OpMultu = 4'd2;
   localparam logic [3:0] OpDiv   = 4'd3;
   localparam logic [3:0] OpDivu  = 4'd4;
   localparam logic [3:0] OpMthi  = 4'd5;
   localparam logic [3:0] OpMtlo  = 4'd6;
   localparam logic [3:0] OpMfhi  = 4'd7;
   localparam logic [3:0] OpMflo  = 4'd8;
   localparam logic [3:0] OpMadd  = 4'd9;
   localparam logic [3:0] OpMaddu = 4'd10;
   localparam logic [3:0] OpMsub  = 4'd11;
   localparam logic [3:0] OpMsubu = 4'd12;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [3:0]  mdu_op;
   logic [31:0] rs_val, rt_val;
   logic        busy, hilo_busy;
   logic [31:0] mdu_out, hi, lo;

   int unsigned errors = 0;
   int unsigned checks = 0;

   logic [63:0] sb[$];   // expected {hi,lo} per issued long op
   logic [63:0] mdl;     // bench's view of {hi,lo}

   e_mdu dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .mdu_op    (mdu_op),
      .rs_val    (rs_val),
      .rt_val    (rt_val),
      .busy      (busy),
      .hilo_busy (hilo_busy),
      .mdu_out   (mdu_out),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Independent reference using 64-bit signed arithmetic.
   function automatic logic [63:0] model_long(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] cur);
      longint sa, sbv, q, r;
      logic [63:0] pu, ps;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      pu  = {32'd0, a} * {32'd0, b};
      ps  = 64'(sa * sbv);
      case (op)
         OpMult:  return ps;
         OpMultu: return pu;
         OpDiv: begin
            if (b == 32'd0) return cur;
            q = sa / sbv;
            r = sa % sbv;
            return {r[31:0], q[31:0]};
         end
         OpDivu: begin
            if (b == 32'd0) return cur;
            return {a % b, a / b};
         end
         OpMadd:  return cur + ps;
         OpMaddu: return cur + pu;
         OpMsub:  return cur - ps;
         OpMsubu: return cur - pu;
         default: return cur;
      endcase
   endfunction

   // Issue a long op at the current falling edge; returns at the first falling edge with
   // busy low. With poke set, an MTHI 0x1234 is driven mid-operation and must be ignored.
   task automatic run_long(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int n, input logic [63:0] exp, input bit poke,
                           input string tag);
      int nb;
      int nhb;
      logic [63:0] got;
      start  = 1'b1;
      mdu_op = op;
      rs_val = a;
      rt_val = b;
      sb.push_back(exp);
      #1;
      check({tag, " prior hilo at start"}, {hi, lo}, mdl);
      check({tag, " hilo_busy at start"}, 64'(hilo_busy), 64'd1);
      nhb = (hilo_busy === 1'b1) ? 1 : 0;
      @(negedge clk);
      start  = 1'b0;
      mdu_op = OpNone;
      nb = 0;
      while (busy === 1'b1 && nb < 200) begin
         nb++;
         if (hilo_busy === 1'b1) nhb++;
         if (poke && nb == 2) begin
            start  = 1'b1;
            mdu_op = OpMthi;
            rs_val = 32'h1234;
         end else begin
            start  = 1'b0;
            mdu_op = OpNone;
         end
         @(negedge clk);
      end
      check({tag, " busy cycles"}, 64'(nb), 64'(n));
      check({tag, " hilo_busy cycles"}, 64'(nhb), 64'(n + 1));
      got = sb.pop_front();
      check({tag, " result {hi,lo}"}, {hi, lo}, got);
      mdl = got;
   endtask

   task automatic write_hl(input logic [3:0] op, input logic [31:0] v, input string tag);
      start  = 1'b1;
      mdu_op = op;
      rs_val = v;
      #1;
      check({tag, " hilo_busy"}, 64'(hilo_busy), 64'd0);
      @(negedge clk);
      start  = 1'b0;
      mdu_op = OpNone;
      if (op == OpMthi) mdl[63:32] = v;
      else              mdl[31:0]  = v;
      check({tag, " busy"}, 64'(busy), 64'd0);
      check({tag, " {hi,lo}"}, {hi, lo}, mdl);
   endtask

   task automatic read_hl(input logic [3:0] op, input logic [31:0] exp, input string tag);
      start  = 1'b1;
      mdu_op = op;
      #1;
      check({tag, " mdu_out"}, 64'(mdu_out), 64'(exp));
      @(negedge clk);
      start  = 1'b0;
      mdu_op = OpNone;
      check({tag, " no state change"}, {hi, lo}, mdl);
   endtask

   logic [3:0]  rop;
   logic [31:0] ra, rb;

   initial begin
      reset_n = 1'b0;
      start   = 1'b0;
      mdu_op  = OpNone;
      rs_val  = '0;
      rt_val  = '0;
      mdl     = '0;
      repeat (2) @(negedge clk);
      check("reset busy", 64'(busy), 64'd0);
      check("reset hilo_busy", 64'(hilo_busy), 64'd0);
      check("reset {hi,lo}", {hi, lo}, 64'd0);
      check("reset mdu_out", 64'(mdu_out), 64'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // Reset mid-DIV aborts and clears HI/LO; nothing commits afterwards.
      write_hl(OpMthi, 32'h55, "pre-reset mthi");
      start  = 1'b1;
      mdu_op = OpDiv;
      rs_val = 32'd100;
      rt_val = 32'd7;
      @(negedge clk);
      start  = 1'b0;
      mdu_op = OpNone;
      repeat (3) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("midop reset busy", 64'(busy), 64'd0);
      check("midop reset {hi,lo}", {hi, lo}, 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      mdl = '0;
      repeat (12) @(negedge clk);
      check("post reset busy", 64'(busy), 64'd0);
      check("post reset no commit", {hi, lo}, 64'd0);

      // Multiplies.
      run_long(OpMult, 32'hFFFF_FFFD, 32'd5, 5, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0, "mult");
      run_long(OpMultu, 32'hFFFF_FFFD, 32'd5, 5, 64'h0000_0004_FFFF_FFF1, 1'b0, "multu");

      // Divides, including divide-by-zero and the signed overflow case.
      run_long(OpDiv, 32'hFFFF_FFF9, 32'd2, 10, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, "div");
      run_long(OpDivu, 32'd7, 32'd0, 10, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, "divu by zero");
      run_long(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 10, 64'h0000_0000_8000_0000, 1'b0,
               "div overflow");

      // MTHI while busy is dropped and the pending result still commits.
      run_long(OpMultu, 32'd3, 32'd7, 5, 64'd21, 1'b1, "mthi during busy");
      write_hl(OpMthi, 32'h1234, "mthi idle");
      read_hl(OpMfhi, 32'h1234, "mfhi");
      write_hl(OpMtlo, 32'hCAFE_0001, "mtlo idle");
      read_hl(OpMflo, 32'hCAFE_0001, "mflo");
      read_hl(OpNone, 32'd0, "none mdu_out");

      // Back-to-back: the second DIV starts on the first cycle busy is low.
      run_long(OpDiv, 32'd100, 32'd7, 10, {32'd2, 32'd14}, 1'b0, "b2b first");
      run_long(OpDiv, 32'hFFFF_FF9C, 32'd7, 10, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 1'b0,
               "b2b second");

`ifdef MDU_MADD_EN
      write_hl(OpMthi, 32'd0, "madd setup hi");
      write_hl(OpMtlo, 32'hFFFF_FFFF, "madd setup lo");
      run_long(OpMaddu, 32'd1, 32'd1, 5, 64'h0000_0001_0000_0000, 1'b0, "maddu");
      run_long(OpMsub, 32'd1, 32'd1, 5, 64'h0000_0000_FFFF_FFFF, 1'b0, "msub");
      run_long(OpMadd, 32'hFFFF_FFFE, 32'd3, 5,
               model_long(OpMadd, 32'hFFFF_FFFE, 32'd3, mdl), 1'b0, "madd");
      run_long(OpMsubu, 32'hFFFF_FFFF, 32'd2, 5,
               model_long(OpMsubu, 32'hFFFF_FFFF, 32'd2, mdl), 1'b0, "msubu");
`else
      // Accumulate codes decode as NONE: no busy, no HI/LO change.
      for (int k = 9; k <= 12; k++) begin
         start  = 1'b1;
         mdu_op = 4'(k);
         rs_val = 32'd3;
         rt_val = 32'd4;
         #1;
         check($sformatf("op%0d hilo_busy", k), 64'(hilo_busy), 64'd0);
         @(negedge clk);
         start  = 1'b0;
         mdu_op = OpNone;
         check($sformatf("op%0d busy", k), 64'(busy), 64'd0);
         check($sformatf("op%0d {hi,lo}", k), {hi, lo}, mdl);
      end
`endif

      // Random mix checked against the reference model.
      for (int i = 0; i < 8; i++) begin
         rop = 4'(1 + $urandom_range(0, 3));
         ra  = $urandom;
         rb  = (i == 5) ? 32'd0 : $urandom;
         if (rop >= OpDiv && (i % 2) == 1) rb = rb >> 20;
         run_long(rop, ra, rb, (rop <= OpMultu) ? 5 : 10, model_long(rop, ra, rb, mdl), 1'b0,
                  $sformatf("rand%0d op%0d", i, rop));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
